// File: rtl/ysyx_23060061_pkg.sv
// Shared fetch-side definitions for the ifu/imem path.
// Holds the default memory base, the responder state encoding and the error word.
package ysyx_23060061_pkg;

  localparam logic [31:0] IMEM_BASE_ADDR = 32'h80000000;
  localparam logic [31:0] IMEM_ERR_DATA  = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } ifu_state_e;

  // Byte address to word index relative to base; the subtraction wraps.
  function automatic logic [31:0] word_index(
    input logic [31:0] addr,
    input logic [31:0] base
  );
    logic [31:0] off;
    off = addr - base;
    return off >> 2;
  endfunction

endpackage

// File: rtl/ysyx_23060061_imem_array.sv
// Instruction word store: synchronous write, combinational read.
// Writes beyond DEPTH are dropped so non-power-of-2 depths stay safe.
module ysyx_23060061_imem_array #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic        wr_ok;
  logic        rd_ok;

  assign wr_ok = 32'(waddr) < 32'(DEPTH);
  assign rd_ok = 32'(raddr) < 32'(DEPTH);

  always_ff @(posedge clk) begin
    if (we && wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = rd_ok ? mem[raddr] : '0;

endmodule

// File: rtl/ysyx_23060061_imem_responder.sv
// Memory end of the fetch channel: one outstanding request,
// word returned LATENCY cycles after acceptance, side port for loading.
module ysyx_23060061_imem_responder
  import ysyx_23060061_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = IMEM_BASE_ADDR,
  localparam int         AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_data,
  output logic          rsp_err,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic [31:0]   fetch_count
);

  localparam int CW    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int CLOAD = (LATENCY > 2) ? (LATENCY - 2) : 0;

  ifu_state_e  state;
  ifu_state_e  state_nxt;
  logic [CW-1:0] cnt;
  logic        accept;
  logic        done;
  logic [31:0] idx;
  logic        addr_err;
  logic [31:0] rd_word;

  assign accept = req_valid && req_ready;
  assign done   = rsp_valid && rsp_ready;

  // Decode is done against the live request; results latch on accept.
  assign idx      = word_index(req_addr, BASE_ADDR);
  assign addr_err = (req_addr[1:0] != 2'b00) || (idx >= 32'(DEPTH));

  ysyx_23060061_imem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (load_en),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (idx[AW-1:0]),
    .rdata (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == IDLE): begin
        if (accept) begin
          state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      (state == WAIT): begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end
      end
      (state == RESP): begin
        if (done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      rsp_data <= IMEM_ERR_DATA;
      rsp_err  <= 1'b0;
    end else if (accept) begin
      cnt      <= CW'(CLOAD);
      rsp_err  <= addr_err;
      rsp_data <= addr_err ? IMEM_ERR_DATA : rd_word;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
    end else if (done) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule
